// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg
// ---------------------------------------------------------------------------
// ID/EX pipeline stage register with valid/ready handshaking. The stage holds
// up to two entries: a main register that drives the outputs, and a skid
// register that catches one extra entry when the consumer stalls.
//
// in_ready_o comes straight from a flop, so there is no combinational path
// from any input to in_ready_o or to any payload output. flush_i drops every
// held entry and any entry offered in the same cycle. Control outputs
// (wb/mem/ex) are forced to zero whenever out_valid_o is low, so a bubble
// never writes the register file or memory. A saturating counter records
// cycles in which a valid entry waited on out_ready_i.
//
// Ports:
//   clk_i, rst_n_i            clock (rising edge), asynchronous active-low reset
//   flush_i                   synchronous flush (bubble insertion)
//   in_valid_i / in_ready_o   upstream handshake (decode stage)
//   wb_i, mem_i, ex_i         control fields in
//   pc_i, rsdata_i, rtdata_i, imm_i, rsaddr_i, rtaddr_i, rdaddr_i  payload in
//   out_valid_o / out_ready_i downstream handshake (execute stage)
//   wb_o, mem_o, ex_o         control fields out, gated by out_valid_o
//   pc_o, rsdata_o, rtdata_o, imm_o, funct_o, rsaddr_o, rtaddr_o, rdaddr_o
//                             payload out from the main register
//   stall_cnt_o, stall_clr_i  saturating stall counter and its clear
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int WB_W   = 2,
  parameter int MEM_W  = 2,
  parameter int EX_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  // upstream
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WB_W-1:0]   wb_i,
  input  logic [MEM_W-1:0]  mem_i,
  input  logic [EX_W-1:0]   ex_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] rsdata_i,
  input  logic [DATA_W-1:0] rtdata_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [ADDR_W-1:0] rsaddr_i,
  input  logic [ADDR_W-1:0] rtaddr_i,
  input  logic [ADDR_W-1:0] rdaddr_i,
  // downstream
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WB_W-1:0]   wb_o,
  output logic [MEM_W-1:0]  mem_o,
  output logic [EX_W-1:0]   ex_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] rsdata_o,
  output logic [DATA_W-1:0] rtdata_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [5:0]        funct_o,
  output logic [ADDR_W-1:0] rsaddr_o,
  output logic [ADDR_W-1:0] rtaddr_o,
  output logic [ADDR_W-1:0] rdaddr_o,
  // performance debug
  output logic [CNT_W-1:0]  stall_cnt_o,
  input  logic              stall_clr_i
);

  localparam int CTRL_W = WB_W + MEM_W + EX_W;
  localparam int PAY_W  = CTRL_W + 4 * DATA_W + 3 * ADDR_W;

  // State encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [PAY_W-1:0] main_q, main_d;
  logic [PAY_W-1:0] skid_q, skid_d;
  logic [PAY_W-1:0] in_pay;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             acc;
  logic             fire;

  assign in_pay = {wb_i, mem_i, ex_i, pc_i, rsdata_i, rtdata_i, imm_i,
                   rsaddr_i, rtaddr_i, rdaddr_i};

  // Ready depends only on the skid flop: the stage can always take one more
  // entry unless the skid slot is already occupied.
  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign acc         = in_valid_i & ~skid_valid_q;
  assign fire        = main_valid_q & out_ready_i;

  // -------------------------------------------------------------------------
  // Next-state / payload steering
  // -------------------------------------------------------------------------
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;

    if (flush_i) begin
      // Drop everything, including an entry offered this cycle. Payload
      // registers keep stale data; outputs are gated by the valid bit.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case ({skid_valid_q, main_valid_q})
        ST_EMPTY: begin
          if (acc) begin
            main_valid_d = 1'b1;
            main_d       = in_pay;
          end
        end
        ST_ONE: begin
          if (acc && fire) begin
            main_d = in_pay;
          end else if (acc) begin
            // Consumer stalled: new (younger) entry parks in the skid slot.
            skid_valid_d = 1'b1;
            skid_d       = in_pay;
          end else if (fire) begin
            main_valid_d = 1'b0;
          end
        end
        ST_FULL: begin
          // acc is impossible here since in_ready_o is low.
          if (fire) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: recover to EMPTY.
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Stall counter: counts cycles a valid entry waits on the consumer.
  // Clear beats increment; saturates instead of wrapping; ignores flush.
  // -------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr_i) begin
      stall_cnt_d = '0;
    end else if (main_valid_q && !out_ready_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic [CTRL_W-1:0] ctrl_raw;
  logic [CTRL_W-1:0] ctrl_gated;

  assign {ctrl_raw, pc_o, rsdata_o, rtdata_o, imm_o,
          rsaddr_o, rtaddr_o, rdaddr_o} = main_q;

  // Bubble gating: control bits are forced low when no valid entry is held.
  generate
    for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
      assign ctrl_gated[gi] = ctrl_raw[gi] & main_valid_q;
    end
  endgenerate

  assign {wb_o, mem_o, ex_o} = ctrl_gated;
  assign funct_o             = imm_o[5:0];
  assign stall_cnt_o         = stall_cnt_q;

endmodule
